// File: rtl/ddr_axi_pkg.sv
// Shared definitions for the DDR AXI write path.
//   AXI_LEN_W  : width of AXI burst length fields (awlen)
//   wr_state_t : write-arbiter FSM states IDLE -> ADDR -> DATA -> RESP
package ddr_axi_pkg;

  localparam int AXI_LEN_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } wr_state_t;

endpackage

// File: rtl/ddr_wr_arbiter.sv
// Two-requester round-robin arbiter for the DDR controller AXI write path.
// A grant covers a whole burst: the AW handshake, every W beat, then the B
// response. Only then is the port rearbitrated.
//
// Ports
//   clk, rstn          : clock, asynchronous active-low reset
//   ddr_ready          : DDR init done; gates new grants only
//   m_aw*/m_w*/m_b*    : two requester ports, packed, requester i at slice i
//   s_aw*/s_w*/s_b*    : single DDR write port
//
// Requester wlast is not used. s_wlast is generated from the latched awlen
// and a beat counter.
module ddr_wr_arbiter
  import ddr_axi_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 128
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      ddr_ready,
  input  logic [2*ADDR_W-1:0]       m_awaddr,
  input  logic [2*AXI_LEN_W-1:0]    m_awlen,
  input  logic [1:0]                m_awvalid,
  output logic [1:0]                m_awready,
  input  logic [2*DATA_W-1:0]       m_wdata,
  input  logic [2*(DATA_W/8)-1:0]   m_wstrb,
  input  logic [1:0]                m_wvalid,
  output logic [1:0]                m_wready,
  output logic [1:0]                m_bvalid,
  input  logic [1:0]                m_bready,
  output logic [ADDR_W-1:0]         s_awaddr,
  output logic [AXI_LEN_W-1:0]      s_awlen,
  output logic                      s_awvalid,
  input  logic                      s_awready,
  output logic [DATA_W-1:0]         s_wdata,
  output logic [(DATA_W/8)-1:0]     s_wstrb,
  output logic                      s_wlast,
  output logic                      s_wvalid,
  input  logic                      s_wready,
  input  logic                      s_bvalid,
  output logic                      s_bready
);

  localparam int STRB_W = DATA_W / 8;

  wr_state_t             state_q, state_d;
  logic                  gnt_q, gnt_d;
  logic                  ptr_q, ptr_d;
  logic [AXI_LEN_W-1:0]  len_q, len_d;
  logic [AXI_LEN_W-1:0]  beat_q, beat_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      ptr_q   <= 1'b0;
      len_q   <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    ptr_d     = ptr_q;
    len_d     = len_q;
    beat_d    = beat_q;
    m_awready = 2'b00;
    m_wready  = 2'b00;
    m_bvalid  = 2'b00;
    s_awvalid = 1'b0;
    s_wvalid  = 1'b0;
    s_wlast   = 1'b0;
    s_bready  = 1'b0;

    case (state_q)
      IDLE: begin
        if (ddr_ready && (|m_awvalid)) begin
          // ptr holds the preferred requester; fall back to the other one
          gnt_d   = m_awvalid[ptr_q] ? ptr_q : ~ptr_q;
          len_d   = gnt_d ? m_awlen[2*AXI_LEN_W-1:AXI_LEN_W] : m_awlen[AXI_LEN_W-1:0];
          beat_d  = '0;
          state_d = ADDR;
        end
      end
      ADDR: begin
        s_awvalid        = m_awvalid[gnt_q];
        m_awready[gnt_q] = s_awready;
        if (s_awvalid && s_awready) state_d = DATA;
      end
      DATA: begin
        s_wvalid        = m_wvalid[gnt_q];
        m_wready[gnt_q] = s_wready;
        // len=255 ends at beat 255, so the compare never needs a 9th bit
        s_wlast         = (beat_q == len_q);
        if (s_wvalid && s_wready) begin
          beat_d = beat_q + AXI_LEN_W'(1);
          if (s_wlast) state_d = RESP;
        end
      end
      RESP: begin
        m_bvalid[gnt_q] = s_bvalid;
        s_bready        = m_bready[gnt_q];
        if (s_bvalid && s_bready) begin
          // last winner drops to lowest priority
          ptr_d   = ~gnt_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Payload follows the current grant; qualified only by the valids above.
  always_comb begin
    s_awaddr = gnt_q ? m_awaddr[2*ADDR_W-1:ADDR_W]       : m_awaddr[ADDR_W-1:0];
    s_awlen  = gnt_q ? m_awlen[2*AXI_LEN_W-1:AXI_LEN_W]  : m_awlen[AXI_LEN_W-1:0];
    s_wdata  = gnt_q ? m_wdata[2*DATA_W-1:DATA_W]        : m_wdata[DATA_W-1:0];
    s_wstrb  = gnt_q ? m_wstrb[2*STRB_W-1:STRB_W]        : m_wstrb[STRB_W-1:0];
  end

endmodule

// File: tb/tb_ddr_wr_arbiter.sv
// Scoreboard bench for ddr_wr_arbiter: stimulus pushes expected AW/W/B
// records in the hand-computed grant order; a monitor pops and compares on
// every DDR-side handshake.
module tb_ddr_wr_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 128;
  localparam int STRB_W = DATA_W / 8;

  typedef struct { logic gnt; logic [31:0] addr; logic [7:0] len; } aw_t;
  typedef struct { logic [127:0] data; logic [15:0] strb; logic last; } w_t;
  typedef struct { logic [31:0] addr; logic [7:0] len; logic [127:0] base; logic [15:0] strb; } burst_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rstn, ddr_ready;
  logic [2*ADDR_W-1:0]    m_awaddr;
  logic [15:0]            m_awlen;
  logic [1:0]             m_awvalid, m_awready;
  logic [2*DATA_W-1:0]    m_wdata;
  logic [2*STRB_W-1:0]    m_wstrb;
  logic [1:0]             m_wvalid, m_wready, m_bvalid, m_bready;
  logic [ADDR_W-1:0]      s_awaddr;
  logic [7:0]             s_awlen;
  logic                   s_awvalid, s_awready;
  logic [DATA_W-1:0]      s_wdata;
  logic [STRB_W-1:0]      s_wstrb;
  logic                   s_wlast, s_wvalid, s_wready, s_bvalid, s_bready;

  int   checks = 0;
  int   errors = 0;
  int   w_hs_cnt = 0;
  logic wr_toggle = 1'b0;
  logic mon_gnt = 1'b0;

  aw_t    exp_aw[$];
  w_t     exp_w[$];
  logic   exp_b[$];
  burst_t req_q0[$];
  burst_t req_q1[$];

  ddr_wr_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rstn(rstn), .ddr_ready(ddr_ready),
    .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bvalid(m_bvalid), .m_bready(m_bready),
    .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid),
    .s_wready(s_wready), .s_bvalid(s_bvalid), .s_bready(s_bready)
  );

  function automatic logic [1:0] oh(input logic g);
    return g ? 2'b10 : 2'b01;
  endfunction

  function automatic int req_size(input int i);
    return (i == 0) ? req_q0.size() : req_q1.size();
  endfunction

  function automatic burst_t req_pop(input int i);
    return (i == 0) ? req_q0.pop_front() : req_q1.pop_front();
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Queue a burst on requester g and push its expected DDR-side records.
  task automatic issue(input logic g, input logic [31:0] addr, input logic [7:0] len,
                       input logic [127:0] base, input logic [15:0] strb);
    burst_t b;
    aw_t    a;
    w_t     w;
    b.addr = addr; b.len = len; b.base = base; b.strb = strb;
    if (g) req_q1.push_back(b); else req_q0.push_back(b);
    a.gnt = g; a.addr = addr; a.len = len;
    exp_aw.push_back(a);
    for (int k = 0; k <= int'(len); k++) begin
      w.data = base + 128'(k);
      w.strb = strb;
      w.last = (k == int'(len));
      exp_w.push_back(w);
    end
    exp_b.push_back(g);
  endtask

  task automatic wait_drain(input string name, input int maxc);
    int n = 0;
    while ((exp_aw.size() + exp_w.size() + exp_b.size()) != 0 && n < maxc) begin
      @(negedge clk);
      n++;
    end
    if (n >= maxc) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got %0d pending records expected 0", name,
               exp_aw.size() + exp_w.size() + exp_b.size());
    end
    repeat (3) @(posedge clk);
  endtask

  // Requester and DDR-slave models: sample handshakes at negedge, update
  // drives just after the following posedge.
  initial begin
    logic [1:0] aw_hs, w_hs, b_hs;
    logic       ddr_last_hs, ddr_b_hs;
    logic [1:0] ph [2];
    logic [7:0] bt [2];
    burst_t     cur [2];
    m_awaddr = '0; m_awlen = '0; m_awvalid = '0;
    m_wdata = '0; m_wstrb = '0; m_wvalid = '0; m_bready = 2'b11;
    s_awready = 1'b1; s_wready = 1'b1; s_bvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin ph[i] = 2'd0; bt[i] = 8'd0; end
    forever begin
      @(negedge clk);
      aw_hs       = m_awvalid & m_awready;
      w_hs        = m_wvalid & m_wready;
      b_hs        = m_bvalid & m_bready;
      ddr_last_hs = s_wvalid & s_wready & s_wlast;
      ddr_b_hs    = s_bvalid & s_bready;
      @(posedge clk);
      #1;
      if (!rstn) begin
        m_awvalid = '0; m_wvalid = '0; s_bvalid = 1'b0; s_wready = 1'b1;
        req_q0.delete(); req_q1.delete();
        for (int i = 0; i < 2; i++) ph[i] = 2'd0;
      end else begin
        s_wready = wr_toggle ? ~s_wready : 1'b1;
        if (ddr_b_hs) s_bvalid = 1'b0;
        else if (ddr_last_hs) s_bvalid = 1'b1;
        for (int i = 0; i < 2; i++) begin
          case (ph[i])
            2'd0: if (req_size(i) > 0) begin
              cur[i] = req_pop(i);
              bt[i]  = 8'd0;
              ph[i]  = 2'd1;
              m_awvalid[i] = 1'b1;
              m_awaddr[i*ADDR_W +: ADDR_W] = cur[i].addr;
              m_awlen[i*8 +: 8] = cur[i].len;
            end
            2'd1: if (aw_hs[i]) begin
              m_awvalid[i] = 1'b0;
              ph[i] = 2'd2;
              m_wvalid[i] = 1'b1;
              m_wdata[i*DATA_W +: DATA_W] = cur[i].base;
              m_wstrb[i*STRB_W +: STRB_W] = cur[i].strb;
            end
            2'd2: if (w_hs[i]) begin
              if (bt[i] == cur[i].len) begin
                m_wvalid[i] = 1'b0;
                ph[i] = 2'd3;
              end else begin
                bt[i] = bt[i] + 8'd1;
                m_wdata[i*DATA_W +: DATA_W] = cur[i].base + 128'(bt[i]);
              end
            end
            default: if (b_hs[i]) ph[i] = 2'd0;
          endcase
        end
      end
    end
  end

  // Monitor
  initial begin
    aw_t  a;
    w_t   w;
    logic g;
    forever begin
      @(negedge clk);
      if (rstn) begin
        if (s_awvalid && s_awready) begin
          if (exp_aw.size() == 0) begin
            checks++; errors++;
            $display("FAIL aw_unexpected: got addr %0h expected no AW", s_awaddr);
          end else begin
            a = exp_aw.pop_front();
            mon_gnt = a.gnt;
            chk("aw_addr", 128'(s_awaddr), 128'(a.addr));
            chk("aw_len", 128'(s_awlen), 128'(a.len));
            chk("aw_grant_awready", 128'(m_awready), 128'(oh(a.gnt)));
          end
        end
        if (s_wvalid && s_wready) begin
          w_hs_cnt++;
          if (exp_w.size() == 0) begin
            checks++; errors++;
            $display("FAIL w_unexpected: got data %0h expected no W", s_wdata);
          end else begin
            w = exp_w.pop_front();
            chk("w_data", 128'(s_wdata), w.data);
            chk("w_strb", 128'(s_wstrb), 128'(w.strb));
            chk("w_last", 128'(s_wlast), 128'(w.last));
            chk("w_grant_wready", 128'(m_wready), 128'(oh(mon_gnt)));
          end
        end
        if (s_bvalid && s_bready) begin
          if (exp_b.size() == 0) begin
            checks++; errors++;
            $display("FAIL b_unexpected: got bvalid %0b expected no B", m_bvalid);
          end else begin
            g = exp_b.pop_front();
            chk("b_grant_bvalid", 128'(m_bvalid), 128'(oh(g)));
          end
        end
      end
    end
  end

  task automatic chk_all_idle(input string tag);
    chk({tag, "_s_awvalid"}, 128'(s_awvalid), 128'(0));
    chk({tag, "_s_wvalid"},  128'(s_wvalid),  128'(0));
    chk({tag, "_s_wlast"},   128'(s_wlast),   128'(0));
    chk({tag, "_s_bready"},  128'(s_bready),  128'(0));
    chk({tag, "_m_awready"}, 128'(m_awready), 128'(0));
    chk({tag, "_m_wready"},  128'(m_wready),  128'(0));
    chk({tag, "_m_bvalid"},  128'(m_bvalid),  128'(0));
  endtask

  // Stimulus
  initial begin
    int w0;
    rstn = 1'b0; ddr_ready = 1'b0; wr_toggle = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_idle("reset");
    @(posedge clk); #2 rstn = 1'b1;

    // 1: grants held off by ddr_ready, then one cycle to s_awvalid
    issue(1'b0, 32'h0000_1000, 8'd0, 128'h0101_0202_0303_0404_0505_0606_0707_0808, 16'h00ff);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t1_gated_awvalid", 128'(s_awvalid), 128'(0));
    end
    @(posedge clk); #2 ddr_ready = 1'b1;
    @(negedge clk); chk("t1_awvalid_same_cycle", 128'(s_awvalid), 128'(0));
    @(negedge clk); chk("t1_awvalid_next_cycle", 128'(s_awvalid), 128'(1));
    wait_drain("t1", 50);

    // 2: single-beat burst, bit-exact payload
    issue(1'b0, 32'h0000_f000, 8'd0, 128'hdeadbeef_cafef00d_12345678_87654321, 16'hffff);
    wait_drain("t2", 50);

    // 3: both requesting from reset -> 0,1,0,1
    @(posedge clk); #2 rstn = 1'b0;
    repeat (2) @(posedge clk);
    #2 rstn = 1'b1;
    issue(1'b0, 32'h0000_2000, 8'd1, 128'h2000_0000_0000_0000_0000_0000_0000_2000, 16'hf0f0);
    issue(1'b1, 32'h8000_3000, 8'd2, 128'h3000_0000_0000_0000_0000_0000_0000_3000, 16'h0f0f);
    issue(1'b0, 32'h0000_4000, 8'd0, 128'h4000_0000_0000_0000_0000_0000_0000_4000, 16'h00ff);
    issue(1'b1, 32'h8000_5000, 8'd1, 128'h5000_0000_0000_0000_0000_0000_0000_5000, 16'hff00);
    wait_drain("t3", 200);

    // 4: four beats with toggling s_wready
    @(posedge clk); #2 wr_toggle = 1'b1;
    w0 = w_hs_cnt;
    issue(1'b0, 32'h0000_6000, 8'd3, 128'h6666_0000_0000_0000_0000_0000_0000_6600, 16'h3c3c);
    wait_drain("t4", 100);
    chk("t4_beat_count", 128'(w_hs_cnt - w0), 128'(4));
    @(posedge clk); #2 wr_toggle = 1'b0;

    // 5: 256-beat burst; ddr_ready drops mid-burst and is ignored
    w0 = w_hs_cnt;
    issue(1'b0, 32'h0001_0000, 8'd255, 128'h5555_aaaa_5555_aaaa_5555_aaaa_5555_0000, 16'hffff);
    for (int n = 0; n < 100 && w_hs_cnt < w0 + 10; n++) @(posedge clk);
    #2 ddr_ready = 1'b0;
    wait_drain("t5", 600);
    chk("t5_beat_count", 128'(w_hs_cnt - w0), 128'(256));
    @(posedge clk); #2 ddr_ready = 1'b1;

    // 6: reset in DATA beat 2 aborts at once; req0 wins afterwards
    w0 = w_hs_cnt;
    issue(1'b1, 32'h8000_6000, 8'd3, 128'h7777_0000_0000_0000_0000_0000_0000_7700, 16'h1111);
    for (int n = 0; n < 100 && w_hs_cnt < w0 + 2; n++) @(posedge clk);
    #1 chk("t6_wvalid_before_reset", 128'(s_wvalid), 128'(1));
    #1 rstn = 1'b0;
    #1 chk_all_idle("t6_reset");
    exp_aw.delete(); exp_w.delete(); exp_b.delete();
    repeat (3) @(posedge clk);
    #2 rstn = 1'b1;
    issue(1'b0, 32'h0000_7000, 8'd0, 128'h0000_7000_0000_7000_0000_7000_0000_7000, 16'h0ff0);
    issue(1'b1, 32'h8000_8000, 8'd0, 128'h0000_8000_0000_8000_0000_8000_0000_8000, 16'hf00f);
    wait_drain("t6", 100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
